// File: rtl/seg_scan_ctrl_if.sv
// Digit write port of the 7-segment scan controller.
// The producer side drives writes through the master modport and the controller receives them on the slave modport.
interface seg_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;

  modport master (output wr_en, output wr_addr, output wr_data, output wr_dp);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  wr_dp);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// A blanking gap at the start of each digit slot suppresses ghosting; an, seg and frame_start are registered.
module seg_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 16
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_ctrl_if.slave      wr,
  input  logic [DIGITS-1:0]   digit_en,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_start
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] DIV_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     div_cnt;
  logic [IW-1:0]     idx;
  logic [3:0]        val [DIGITS];
  logic              dp  [DIGITS];

  logic              wr_ok;
  logic [IW-1:0]     wr_idx;
  logic [DIGITS-1:0] an_nxt;
  logic [7:0]        seg_nxt;
  logic              frame_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign wr_ok  = ({29'd0, wr.wr_addr} < 32'(DIGITS));
  assign wr_idx = wr.wr_addr[IW-1:0];

  // Digit storage; reset wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        val[i] <= '0;
        dp[i]  <= 1'b0;
      end
    end else if (wr.wr_en && wr_ok) begin
      val[wr_idx] <= wr.wr_data;
      dp[wr_idx]  <= wr.wr_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_BLANK;
    else     state <= state_nxt;
  end

  // state always equals (div_cnt >= BLANK) for the current div_cnt
  always_comb begin
    state_nxt = state;
    an_nxt    = '1;
    seg_nxt   = 8'hFF;
    frame_nxt = (div_cnt == '0) && (idx == '0);
    case (state)
      S_BLANK: begin
        if (div_cnt == BLANK_LAST) state_nxt = S_SHOW;
      end
      S_SHOW: begin
        if (div_cnt == DIV_LAST) state_nxt = S_BLANK;
        if (digit_en[idx]) begin
          an_nxt[idx] = 1'b0;
          seg_nxt     = {decode(val[idx]), ~dp[idx]};
        end
      end
      default: state_nxt = S_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= '1;
      seg         <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nxt;
      seg         <= seg_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random writes, enables and resets,
// compared every cycle against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int SD     = 8;
  localparam int BL     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DIGITS-1:0] digit_en = '1;
  logic [7:0]        seg;
  logic [DIGITS-1:0] an;
  logic              frame_start;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SD), .BLANK(BL)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (bus.slave),
    .digit_en    (digit_en),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Segment patterns a..g, active-low
  logic [6:0]  seg_rom [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [3:0]  mval [DIGITS];
  logic        mdp  [DIGITS];
  int unsigned tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s tick=%0d got=%0h expected=%0h", tag, tick, got, exp);
    end
  endtask

  // One clock: drive inputs, predict outputs from the pre-edge model, update model, compare
  task automatic cycle(input logic r, input logic we, input logic [2:0] wa,
                       input logic [3:0] wd, input logic wdp, input logic [DIGITS-1:0] den);
    logic [DIGITS-1:0] e_an;
    logic [7:0]        e_seg;
    logic              e_fs;
    int unsigned       pos, d;
    @(negedge clk);
    rst         = r;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_dp   = wdp;
    digit_en    = den;
    @(posedge clk);
    e_an  = '1;
    e_seg = 8'hFF;
    e_fs  = 1'b0;
    if (r) begin
      for (int i = 0; i < DIGITS; i++) begin
        mval[i] = '0;
        mdp[i]  = 1'b0;
      end
      tick = 0;
    end else begin
      pos  = tick % SD;
      d    = (tick / SD) % DIGITS;
      e_fs = ((tick % (SD * DIGITS)) == 0);
      if (pos >= BL && den[d]) begin
        e_an[d] = 1'b0;
        e_seg   = {seg_rom[mval[d]], ~mdp[d]};
      end
      if (we && wa < DIGITS) begin
        mval[wa] = wd;
        mdp[wa]  = wdp;
      end
      tick++;
    end
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic idle(input logic [DIGITS-1:0] den);
    cycle(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, den);
  endtask

  initial begin
    logic              r, we, wdp;
    logic [2:0]        wa;
    logic [3:0]        wd;
    logic [DIGITS-1:0] den;
    int                guard;
    tick        = 0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_dp   = 1'b0;

    repeat (3) cycle(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 4'hF);
    repeat (70) idle(4'hF);

    cycle(1'b0, 1'b1, 3'd0, 4'h1, 1'b0, 4'hF);
    cycle(1'b0, 1'b1, 3'd1, 4'hA, 1'b0, 4'hF);
    cycle(1'b0, 1'b1, 3'd2, 4'h7, 1'b1, 4'hF);
    cycle(1'b0, 1'b1, 3'd3, 4'hF, 1'b0, 4'hF);
    repeat (40) idle(4'hF);

    repeat (40) idle(4'b1011);

    // Write to the digit currently lit
    guard = 0;
    while (!((tick % SD) == 4) && guard < 64) begin
      idle(4'hF);
      guard++;
    end
    cycle(1'b0, 1'b1, 3'(((tick / SD) % DIGITS)), 4'h8, 1'b0, 4'hF);
    repeat (6) idle(4'hF);

    cycle(1'b0, 1'b1, 3'd5, 4'h3, 1'b1, 4'hF);
    repeat (40) idle(4'hF);

    // Reset in the middle of slot 2, with a competing write
    guard = 0;
    while (!(((tick / SD) % DIGITS) == 2 && (tick % SD) == 4) && guard < 64) begin
      idle(4'hF);
      guard++;
    end
    cycle(1'b1, 1'b1, 3'd2, 4'h9, 1'b1, 4'hF);
    repeat (40) idle(4'hF);

    den = '1;
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      we  = ($urandom_range(0, 4) == 0);
      wa  = 3'($urandom_range(0, 7));
      wd  = 4'($urandom);
      wdp = 1'($urandom);
      if ($urandom_range(0, 20) == 0) den = DIGITS'($urandom);
      cycle(r, we, wa, wd, wdp, den);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a common-anode, multi-digit 7-segment display. It holds one 4-bit hex value and one decimal-point bit per digit and steps through the digits in turn. Each selected value goes through a single shared hex-to-segment decoder, with a short blanking gap between digits to suppress ghosting. It sits between the digit-producing logic (counters, FSM status) and the board's segment/anode pins.

## Interface
- DIGITS, 8: number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot; must be at least 2.
- BLANK, 16: cycles at the start of each slot with all outputs blanked; legal range 1..SCAN_DIV-1.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  digit write strobe, one cycle per write.
- wr_addr  in  3  digit index to write; writes with wr_addr ≥ DIGITS are ignored.
- wr_data  in  4  hex value 0..F for the addressed digit.
- wr_dp  in  1  decimal point for the addressed digit (1 = lit).
- digit_en  in  DIGITS  per-digit enable; 0 keeps that digit dark during its slot, but the slot time is still consumed.
- seg  out  8  segment drive, active-low; bit7..bit0 = a,b,c,d,e,f,g,dp.
- an  out  DIGITS  anode select, active-low, at most one bit low.
- frame_start  out  1  one-cycle pulse marking the start of digit 0's slot.

## Operation
- Storage: val[DIGITS] (4 bits each) and dp[DIGITS]. On wr_en with a valid address, the entry is updated at that clock edge.
- Counters:
  - div_cnt runs 0..SCAN_DIV-1 and wraps.
  - On a div_cnt wrap, idx advances 0..DIGITS-1 and wraps to 0.
- Two-state FSM per slot:
  - BLANK: div_cnt < BLANK. Outputs an = all 1, seg = 8'hFF.
  - SHOW: div_cnt ≥ BLANK. Outputs an[idx] = ~digit_en[idx] (all other bits 1), seg = {decode(val[idx]), ~dp[idx]}.
  - If digit_en[idx] = 0, seg = 8'hFF as well.
- Transitions:
  - BLANK→SHOW when div_cnt reaches BLANK.
  - SHOW→BLANK when div_cnt wraps, which is also when idx advances.
- Decoder, active-low segments a..g with a as the MSB of the 7-bit field:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- frame_start is asserted for the cycle corresponding to div_cnt = 0 with idx = 0.
- A write to the digit currently in SHOW takes effect mid-slot with no other side effect on the scan.
- digit_en is sampled every cycle and is not latched per slot.

## Timing
- Reset values:
  - div_cnt = 0, idx = 0, FSM = BLANK.
  - All val = 0, all dp = 0.
  - an = all 1, seg = 8'hFF, frame_start = 0.
- an, seg and frame_start are registered. Each reflects the div_cnt/idx/storage values present before the same edge, so there is one cycle of lag.
- Write latency: a write at edge E updates storage at E. If that digit is in SHOW, seg changes at edge E+1.
- First lit output after reset release: an[0] goes low at the (BLANK+1)th rising edge after rst deasserts. frame_start pulses at the first edge after release.
- Slot period is SCAN_DIV cycles. Frame period is DIGITS·SCAN_DIV cycles. Lit time per slot is SCAN_DIV−BLANK cycles.
- rst asserted mid-slot: all outputs and storage return to their reset values at the next edge, and scanning restarts at digit 0.
- rst has priority over wr_en in the same cycle; the write is lost.

## Test plan
Parameters for all scenarios: DIGITS=4, SCAN_DIV=8, BLANK=2.
- Reset then idle, all digit_en=1:
  - an = 1111 and seg = FF for 2 cycles.
  - Then an = 1110, seg = 0x03 ("0", dp off) for 6 cycles.
  - Then blank for 2 cycles, then an = 1101.
  - frame_start pulses every 32 cycles.
- Write 1 to digit 0, A to digit 1, 7 to digit 2, F to digit 3, with wr_dp = 1 on digit 2:
  - SHOW seg values are 0x9F, 0x11, 0x1E, 0x71 in digit order.
- digit_en = 1011:
  - During slot 2, an = 1111 and seg = FF for all 8 cycles.
  - Slots 0, 1 and 3 are unaffected.
- Write to the digit currently in SHOW, value 8:
  - seg becomes 0x01 exactly one cycle after the write edge.
  - an stays unchanged.
- Write with wr_addr = 5: no storage change, and the display is unchanged over a full frame.
- Assert rst for 1 cycle in the middle of slot 2:
  - Next cycle: an = 1111, seg = FF, all values cleared.
  - an[0] goes low 3 edges after rst deasserts.
